// File: rtl/pattern_bank.sv
// -----------------------------------------------------------------------------
// pattern_bank
//   Bank of NUM_BUFS pattern buffers, each DEPTH fields of WIDTH bits, held in
//   flops. Each buffer can be loaded and read back through a per-buffer serial
//   scan chain. Single fields can be written and read through a field port.
//   One buffer is "active" and is presented in full on current_buffer. A switch
//   of the active buffer is requested with sel_req/sel_idx and only takes
//   effect on a frame strobe, so the pattern engine never sees a torn buffer.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   ssel/saddr        serial interface select and addressed buffer
//   sshift/sin        shift strobe and serial data in (enters field 0 bit 0)
//   sout              registered serial out: tail of saddr buffer, pre-shift
//   sel_req/sel_idx   active-buffer switch request and target index
//   frame             frame strobe; a pending switch is applied here
//   sel_busy          switch pending; further requests are ignored
//   sel_err           1-cycle pulse on a request with an out-of-range index
//   active_idx        index of the active buffer
//   current_buffer    active buffer contents, field k at [k*WIDTH +: WIDTH]
//   fld_buf           buffer used by the field read and write ports
//   fld_rd_addr       field read address; fld_rd_data is 1-cycle registered
//   fld_wr*           field write enable/address/data
//   wr_drop           1-cycle pulse: field write lost to a same-cycle shift
// -----------------------------------------------------------------------------
module pattern_bank #(
    parameter int NUM_BUFS = 8,
    parameter int DEPTH    = 22,
    parameter int WIDTH    = 8,
    parameter int BUF_AW   = $clog2(NUM_BUFS),
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ssel,
    input  logic [BUF_AW-1:0]        saddr,
    input  logic                     sshift,
    input  logic                     sin,
    output logic                     sout,
    input  logic                     sel_req,
    input  logic [BUF_AW-1:0]        sel_idx,
    input  logic                     frame,
    output logic                     sel_busy,
    output logic                     sel_err,
    output logic [BUF_AW-1:0]        active_idx,
    output logic [DEPTH*WIDTH-1:0]   current_buffer,
    input  logic [BUF_AW-1:0]        fld_buf,
    input  logic [ADDR_W-1:0]        fld_rd_addr,
    output logic [WIDTH-1:0]         fld_rd_data,
    input  logic                     fld_wr,
    input  logic [ADDR_W-1:0]        fld_wr_addr,
    input  logic [WIDTH-1:0]         fld_wr_data,
    output logic                     wr_drop
);

    localparam int CHAIN_W = DEPTH * WIDTH;

    typedef enum logic [0:0] {
        SW_IDLE = 1'b0,
        SW_PEND = 1'b1
    } sw_state_e;

    // Index range helpers; indices are narrower than an int, so widen first.
    function automatic logic buf_valid(input logic [BUF_AW-1:0] idx);
        return (int'(idx) < NUM_BUFS);
    endfunction

    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return (int'(addr) < DEPTH);
    endfunction

    // Storage: each buffer is kept as its scan chain, field 0 in the LSBs.
    logic [CHAIN_W-1:0] buf_q [NUM_BUFS];
    logic [CHAIN_W-1:0] buf_d [NUM_BUFS];

    sw_state_e          state_q, state_d;
    logic [BUF_AW-1:0]  pending_q, pending_d;
    logic [BUF_AW-1:0]  active_q, active_d;
    logic               sel_err_q, sel_err_d;
    logic               wr_drop_q, wr_drop_d;
    logic               sout_q, sout_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;

    logic [NUM_BUFS-1:0] shift_hit_s;
    logic [NUM_BUFS-1:0] wr_hit_s;
    logic                wr_ok_s;
    logic                tail_s;
    logic [WIDTH-1:0]    rd_word_s;
    logic [CHAIN_W-1:0]  cur_s;

    // A field write is only considered when both its buffer and address exist.
    assign wr_ok_s = fld_wr & buf_valid(fld_buf) & addr_valid(fld_wr_addr);

    // Per-buffer shift and write decode; a shift always wins over a write.
    always_comb begin
        for (int b = 0; b < NUM_BUFS; b++) begin
            shift_hit_s[b] = ssel & sshift & (saddr == BUF_AW'(b));
            wr_hit_s[b]    = wr_ok_s & (fld_buf == BUF_AW'(b)) & ~shift_hit_s[b];
        end
    end

    // A write loses only when its own (valid) buffer is shifting this cycle.
    assign wr_drop_d = wr_ok_s & ssel & sshift & (saddr == fld_buf);

    // Next-state of the buffer storage: shift, field write, or hold.
    always_comb begin
        for (int b = 0; b < NUM_BUFS; b++) begin
            buf_d[b] = buf_q[b];
            if (shift_hit_s[b]) begin
                buf_d[b] = {buf_q[b][CHAIN_W-2:0], sin};
            end else if (wr_hit_s[b]) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (fld_wr_addr == ADDR_W'(k)) begin
                        buf_d[b][k*WIDTH +: WIDTH] = fld_wr_data;
                    end else begin
                        buf_d[b][k*WIDTH +: WIDTH] = buf_q[b][k*WIDTH +: WIDTH];
                    end
                end
            end else begin
                buf_d[b] = buf_q[b];
            end
        end
    end

    // Serial out: pre-shift tail of the addressed buffer; 0 if none matches.
    always_comb begin
        tail_s = 1'b0;
        for (int b = 0; b < NUM_BUFS; b++) begin
            tail_s = tail_s | ((saddr == BUF_AW'(b)) & buf_q[b][CHAIN_W-1]);
        end
        sout_d = ssel & tail_s;
    end

    // Field read mux; out-of-range buffer/address matches nothing and reads 0.
    always_comb begin
        rd_word_s = {WIDTH{1'b0}};
        for (int b = 0; b < NUM_BUFS; b++) begin
            for (int k = 0; k < DEPTH; k++) begin
                rd_word_s = rd_word_s |
                    (((fld_buf == BUF_AW'(b)) && (fld_rd_addr == ADDR_W'(k)))
                        ? buf_q[b][k*WIDTH +: WIDTH] : {WIDTH{1'b0}});
            end
        end
        // Write-first: a write that actually lands this cycle bypasses storage.
        if (wr_ok_s && !wr_drop_d && (fld_wr_addr == fld_rd_addr)) begin
            rd_data_d = fld_wr_data;
        end else begin
            rd_data_d = rd_word_s;
        end
    end

    // Active-buffer view, straight from storage so it tracks the flops.
    always_comb begin
        cur_s = {CHAIN_W{1'b0}};
        for (int b = 0; b < NUM_BUFS; b++) begin
            cur_s = cur_s | ((active_q == BUF_AW'(b)) ? buf_q[b] : {CHAIN_W{1'b0}});
        end
    end

    // Switch FSM next-state: capture a request in IDLE, apply it on frame.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        active_d  = active_q;
        sel_err_d = 1'b0;
        case (state_q)
            SW_IDLE: begin
                // frame is ignored here, so a request arriving with a frame
                // waits for the following frame.
                if (sel_req) begin
                    if (buf_valid(sel_idx)) begin
                        pending_d = sel_idx;
                        state_d   = SW_PEND;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end else begin
                    state_d = SW_IDLE;
                end
            end
            SW_PEND: begin
                if (frame) begin
                    active_d = pending_q;
                    state_d  = SW_IDLE;
                end else begin
                    state_d = SW_PEND;
                end
            end
            default: begin
                state_d = SW_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset clearing storage and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BUFS; b++) begin
                buf_q[b] <= {CHAIN_W{1'b0}};
            end
            state_q   <= SW_IDLE;
            pending_q <= {BUF_AW{1'b0}};
            active_q  <= {BUF_AW{1'b0}};
            sel_err_q <= 1'b0;
            wr_drop_q <= 1'b0;
            sout_q    <= 1'b0;
            rd_data_q <= {WIDTH{1'b0}};
        end else begin
            for (int b = 0; b < NUM_BUFS; b++) begin
                buf_q[b] <= buf_d[b];
            end
            state_q   <= state_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            sel_err_q <= sel_err_d;
            wr_drop_q <= wr_drop_d;
            sout_q    <= sout_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign sout           = sout_q;
    assign sel_busy       = (state_q == SW_PEND);
    assign sel_err        = sel_err_q;
    assign active_idx     = active_q;
    assign current_buffer = cur_s;
    assign fld_rd_data    = rd_data_q;
    assign wr_drop        = wr_drop_q;

endmodule

// File: tb/tb_pattern_bank.sv
// -----------------------------------------------------------------------------
// tb_pattern_bank
//   Directed bench for pattern_bank. The main instance uses the default
//   geometry (8 buffers x 22 fields x 8 bits); a second instance uses
//   6 buffers x 16 fields x 12 bits to exercise out-of-range select indices
//   and a different field width.
// -----------------------------------------------------------------------------
module tb_pattern_bank;

    logic         clk;
    logic         rst;

    // Main instance (8 x 22 x 8)
    logic         ssel, sshift, sin, sout;
    logic [2:0]   saddr;
    logic         sel_req, frame, sel_busy, sel_err;
    logic [2:0]   sel_idx, active_idx;
    logic [175:0] current_buffer;
    logic [2:0]   fld_buf;
    logic [4:0]   fld_rd_addr, fld_wr_addr;
    logic [7:0]   fld_rd_data, fld_wr_data;
    logic         fld_wr, wr_drop;

    // Alternate instance (6 x 16 x 12)
    logic         a_ssel, a_sshift, a_sin, a_sout;
    logic [2:0]   a_saddr;
    logic         a_sel_req, a_frame, a_sel_busy, a_sel_err;
    logic [2:0]   a_sel_idx, a_active_idx;
    logic [191:0] a_current_buffer;
    logic [2:0]   a_fld_buf;
    logic [3:0]   a_fld_rd_addr, a_fld_wr_addr;
    logic [11:0]  a_fld_rd_data, a_fld_wr_data;
    logic         a_fld_wr, a_wr_drop;

    int checks;
    int failures;

    pattern_bank dut (
        .clk(clk), .rst(rst),
        .ssel(ssel), .saddr(saddr), .sshift(sshift), .sin(sin), .sout(sout),
        .sel_req(sel_req), .sel_idx(sel_idx), .frame(frame),
        .sel_busy(sel_busy), .sel_err(sel_err), .active_idx(active_idx),
        .current_buffer(current_buffer),
        .fld_buf(fld_buf), .fld_rd_addr(fld_rd_addr), .fld_rd_data(fld_rd_data),
        .fld_wr(fld_wr), .fld_wr_addr(fld_wr_addr), .fld_wr_data(fld_wr_data),
        .wr_drop(wr_drop)
    );

    pattern_bank #(.NUM_BUFS(6), .DEPTH(16), .WIDTH(12)) dut_alt (
        .clk(clk), .rst(rst),
        .ssel(a_ssel), .saddr(a_saddr), .sshift(a_sshift), .sin(a_sin), .sout(a_sout),
        .sel_req(a_sel_req), .sel_idx(a_sel_idx), .frame(a_frame),
        .sel_busy(a_sel_busy), .sel_err(a_sel_err), .active_idx(a_active_idx),
        .current_buffer(a_current_buffer),
        .fld_buf(a_fld_buf), .fld_rd_addr(a_fld_rd_addr), .fld_rd_data(a_fld_rd_data),
        .fld_wr(a_fld_wr), .fld_wr_addr(a_fld_wr_addr), .fld_wr_data(a_fld_wr_data),
        .wr_drop(a_wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [255:0] exp_cb;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        ssel = 1'b0; sshift = 1'b0; sin = 1'b0; saddr = 3'd0;
        sel_req = 1'b0; sel_idx = 3'd0; frame = 1'b0;
        fld_buf = 3'd0; fld_rd_addr = 5'd0; fld_wr = 1'b0; fld_wr_addr = 5'd0; fld_wr_data = 8'h00;
        a_ssel = 1'b0; a_sshift = 1'b0; a_sin = 1'b0; a_saddr = 3'd0;
        a_sel_req = 1'b0; a_sel_idx = 3'd0; a_frame = 1'b0;
        a_fld_buf = 3'd0; a_fld_rd_addr = 4'd0; a_fld_wr = 1'b0; a_fld_wr_addr = 4'd0;
        a_fld_wr_data = 12'h000;

        // ---- Reset state ----
        step();
        step();
        rst = 1'b0;
        check("rst_active", 256'(active_idx), 256'd0);
        check("rst_busy", 256'(sel_busy), 256'd0);
        check("rst_err", 256'(sel_err), 256'd0);
        check("rst_drop", 256'(wr_drop), 256'd0);
        check("rst_sout", 256'(sout), 256'd0);
        check("rst_rd", 256'(fld_rd_data), 256'd0);
        check("rst_cur", 256'(current_buffer), 256'd0);
        check("rst_alt_active", 256'(a_active_idx), 256'd0);
        check("rst_alt_cur", 256'(a_current_buffer), 256'd0);

        // ---- 1: serial load of buffer 2 with 0,1,0,1... (last bit in is 1) ----
        // Bit j of the chain receives the bit shifted in at step 175-j, so
        // even bits end up 1 and every field reads 8'h55.
        ssel = 1'b1; saddr = 3'd2; sshift = 1'b1;
        for (int i = 0; i < 176; i++) begin
            sin = i[0];
            step();
        end
        sshift = 1'b0; sin = 1'b0;
        fld_buf = 3'd2; fld_rd_addr = 5'd0;
        step();
        check("load_f0", 256'(fld_rd_data), 256'h55);
        fld_rd_addr = 5'd21;
        step();
        check("load_f21", 256'(fld_rd_data), 256'h55);
        fld_buf = 3'd1; fld_rd_addr = 5'd5;
        step();
        check("other_buf_zero", 256'(fld_rd_data), 256'h00);
        check("active_untouched", 256'(current_buffer), 256'd0);
        // Readback: shift i emits chain bit 175-i, which is 1 when i is odd.
        sshift = 1'b1;
        for (int i = 0; i < 176; i++) begin
            step();
            check("readback_sout", 256'(sout), 256'(i[0]));
        end
        sshift = 1'b0; ssel = 1'b0;
        fld_buf = 3'd2; fld_rd_addr = 5'd0;
        step();
        check("after_readback_zero", 256'(fld_rd_data), 256'h00);
        check("sout_ssel_low", 256'(sout), 256'd0);

        // ---- 2: field write / read ----
        fld_buf = 3'd3; fld_rd_addr = 5'd21;
        step();
        check("rd_before_wr", 256'(fld_rd_data), 256'h00);
        fld_wr = 1'b1; fld_wr_addr = 5'd21; fld_wr_data = 8'hA5;
        check("rd_old_during_wr", 256'(fld_rd_data), 256'h00);
        step();
        check("rd_write_first_a5", 256'(fld_rd_data), 256'hA5);
        fld_wr = 1'b0;
        step();
        check("rd_next_a5", 256'(fld_rd_data), 256'hA5);
        fld_wr = 1'b1; fld_wr_data = 8'h3C;
        step();
        check("rd_write_first_3c", 256'(fld_rd_data), 256'h3C);
        fld_wr_addr = 5'd25; fld_rd_addr = 5'd25; fld_wr_data = 8'hFF;
        step();
        check("rd_oor_addr", 256'(fld_rd_data), 256'h00);
        check("wr_oor_no_drop", 256'(wr_drop), 256'd0);
        fld_wr = 1'b0; fld_rd_addr = 5'd21;
        step();
        check("rd_3c_kept", 256'(fld_rd_data), 256'h3C);
        fld_buf = 3'd5; fld_wr = 1'b1; fld_wr_addr = 5'd4; fld_wr_data = 8'h77;
        step();
        fld_wr = 1'b0;

        // ---- 3: switch waits for frame ----
        sel_req = 1'b1; sel_idx = 3'd5;
        step();
        sel_req = 1'b0;
        check("busy_after_req", 256'(sel_busy), 256'd1);
        for (int i = 0; i < 10; i++) step();
        check("no_frame_active", 256'(active_idx), 256'd0);
        check("no_frame_busy", 256'(sel_busy), 256'd1);
        sel_req = 1'b1; sel_idx = 3'd6;
        step();
        sel_req = 1'b0;
        check("req_in_pend_no_err", 256'(sel_err), 256'd0);
        frame = 1'b1;
        step();
        frame = 1'b0;
        check("frame_active5", 256'(active_idx), 256'd5);
        check("frame_busy0", 256'(sel_busy), 256'd0);
        exp_cb = 256'h77 << 32;
        check("cur_buf5", 256'(current_buffer), exp_cb);

        // ---- 4: request on a frame cycle waits for the next frame ----
        sel_req = 1'b1; sel_idx = 3'd4; frame = 1'b1;
        step();
        sel_req = 1'b0; frame = 1'b0;
        check("req_frame_same_active", 256'(active_idx), 256'd5);
        check("req_frame_same_busy", 256'(sel_busy), 256'd1);
        step();
        frame = 1'b1;
        step();
        frame = 1'b0;
        check("next_frame_active4", 256'(active_idx), 256'd4);
        check("next_frame_busy0", 256'(sel_busy), 256'd0);
        frame = 1'b1;
        step();
        frame = 1'b0;
        check("idle_frame_noop", 256'(active_idx), 256'd4);

        // ---- 5: write vs shift conflict ----
        ssel = 1'b1; saddr = 3'd1; sshift = 1'b1; sin = 1'b1;
        fld_wr = 1'b1; fld_buf = 3'd1; fld_wr_addr = 5'd0; fld_wr_data = 8'hFF;
        step();
        check("conflict_drop", 256'(wr_drop), 256'd1);
        sshift = 1'b0; fld_wr = 1'b0; fld_rd_addr = 5'd0;
        step();
        check("drop_pulse_end", 256'(wr_drop), 256'd0);
        check("conflict_shift_only", 256'(fld_rd_data), 256'h01);
        sshift = 1'b1; sin = 1'b0;
        fld_wr = 1'b1; fld_buf = 3'd2; fld_wr_addr = 5'd0; fld_wr_data = 8'h5A;
        step();
        check("other_buf_no_drop", 256'(wr_drop), 256'd0);
        check("other_buf_write", 256'(fld_rd_data), 256'h5A);
        sshift = 1'b0; fld_wr = 1'b0; fld_buf = 3'd1;
        step();
        check("buf1_shifted_twice", 256'(fld_rd_data), 256'h02);

        // ---- 6: reset while pending and mid-shift ----
        ssel = 1'b0;
        sel_req = 1'b1; sel_idx = 3'd2;
        step();
        sel_req = 1'b0;
        fld_wr = 1'b1; fld_buf = 3'd6; fld_wr_addr = 5'd21; fld_wr_data = 8'h80;
        step();
        fld_wr = 1'b0; fld_buf = 3'd3; fld_rd_addr = 5'd21;
        ssel = 1'b1; saddr = 3'd6;
        step();
        check("pre_rst_sout", 256'(sout), 256'd1);
        check("pre_rst_rd", 256'(fld_rd_data), 256'h3C);
        check("pre_rst_busy", 256'(sel_busy), 256'd1);
        sshift = 1'b1; sin = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; sshift = 1'b0; ssel = 1'b0;
        check("rst_mid_active", 256'(active_idx), 256'd0);
        check("rst_mid_busy", 256'(sel_busy), 256'd0);
        check("rst_mid_sout", 256'(sout), 256'd0);
        check("rst_mid_rd", 256'(fld_rd_data), 256'h00);
        check("rst_mid_cur", 256'(current_buffer), 256'd0);
        step();
        check("rst_cleared_buf3", 256'(fld_rd_data), 256'h00);
        fld_buf = 3'd6;
        frame = 1'b1;
        step();
        frame = 1'b0;
        check("rst_cleared_buf6", 256'(fld_rd_data), 256'h00);
        check("pending_discarded", 256'(active_idx), 256'd0);

        // ---- Alternate geometry: 6 buffers x 16 fields x 12 bits ----
        a_sel_req = 1'b1; a_sel_idx = 3'd7;
        step();
        check("alt_err7", 256'(a_sel_err), 256'd1);
        check("alt_err7_busy", 256'(a_sel_busy), 256'd0);
        a_sel_idx = 3'd6;
        step();
        check("alt_err6", 256'(a_sel_err), 256'd1);
        a_sel_req = 1'b0;
        step();
        check("alt_err_pulse_end", 256'(a_sel_err), 256'd0);
        a_fld_wr = 1'b1; a_fld_buf = 3'd5; a_fld_wr_addr = 4'd15; a_fld_wr_data = 12'hABC;
        a_fld_rd_addr = 4'd15;
        step();
        a_fld_wr = 1'b0;
        check("alt_rd_abc", 256'(a_fld_rd_data), 256'hABC);
        a_ssel = 1'b1; a_saddr = 3'd0; a_sshift = 1'b1; a_sin = 1'b1;
        for (int i = 0; i < 12; i++) step();
        a_sshift = 1'b0;
        a_fld_buf = 3'd0; a_fld_rd_addr = 4'd0;
        step();
        check("alt_shift_f0", 256'(a_fld_rd_data), 256'hFFF);
        a_fld_rd_addr = 4'd1;
        step();
        check("alt_shift_f1", 256'(a_fld_rd_data), 256'h000);
        a_saddr = 3'd6; a_sshift = 1'b1;
        step();
        a_sshift = 1'b0; a_ssel = 1'b0;
        check("alt_sout_oor", 256'(a_sout), 256'd0);
        a_fld_rd_addr = 4'd0;
        step();
        check("alt_oor_shift_noop", 256'(a_fld_rd_data), 256'hFFF);
        a_sel_req = 1'b1; a_sel_idx = 3'd5;
        step();
        a_sel_req = 1'b0; a_frame = 1'b1;
        step();
        a_frame = 1'b0;
        check("alt_active5", 256'(a_active_idx), 256'd5);
        exp_cb = 256'hABC << 180;
        check("alt_cur_buf5", 256'(a_current_buffer), exp_cb);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
